netlist_writer: RTL and testbench
=================================

// Module: netlist_writer
// PURPOSE
//  Builds the gate-level netlist image that the garbling-side netlist reader consumes from its 32-bit memory.
//  Latches the header counts, then emits the 4 header words at addresses 0..3.
//  Then accepts gate records over a valid/ready stream and writes one packed word per gate at address 4+k.
//  Checks operand ordering and the XOR count. Raises done when the image is complete.
// PARAMETERS
//  S  13  index/count width; in0 field = bits [31:S+5], so S <= 13 keeps the header fields and gate fields inside 32 bits
// PORTS
//  clk          in   1   clock
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   begin a new image (sampled only in IDLE)
//  init_size    in   S   header count, latched on start
//  input_size   in   S   header count, latched on start
//  dff_size     in   S   header count, latched on start
//  output_size  in   S   header count, latched on start
//  gate_size    in   S   header count, latched on start
//  num_XOR      in   S   header count, latched on start
//  g_valid      in   1   gate record valid
//  g_ready      out  1   gate record accepted when g_valid & g_ready
//  g_in0        in   S   operand 0 wire index
//  g_in1        in   S   operand 1 wire index
//  g_logic      in   4   gate truth table; 4'b0110 = XOR
//  g_is_output  in   1   gate output is a circuit output
//  mem_we       out  1   memory write strobe
//  mem_addr     out  S   memory word address
//  mem_wdata    out  32  memory word
//  busy         out  1   high from the cycle after start until done
//  done         out  1   one-cycle pulse when the image is complete
//  err          out  1   sticky error; cleared on the next accepted start
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; gate counter k=0, xor counter=0. Memory contents are not cleared.
//  States: IDLE -> HDR (4 cycles) -> GATES -> FIN -> IDLE.
//  IDLE:
//   - start=1: latch all six counts, clear err, go to HDR.
//   - If gate_size > 2**S-5: set err, stay in IDLE.
//  HDR: mem_we=1 for 4 consecutive cycles; mem_addr = 0,1,2,3. Unused word bits are 0.
//   - word0 = init_size in bits [S-1:0].
//   - word1 = input_size in bits [S-1:0].
//   - word2 = {dff_size at [2S-1:S], output_size at [S-1:0]}.
//   - word3 = {num_XOR at [2S-1:S], gate_size at [S-1:0]}.
//   - After word3: go to GATES, or to FIN directly if gate_size==0.
//  GATES:
//   - g_ready=1 combinationally while in GATES and k<gate_size; 0 in every other state.
//   - On accept, the next cycle drives mem_we=1, mem_addr=4+k.
//   - mem_wdata = {g_in0 zero-extended to 27-S bits at [31:S+5], g_in1 at [S+4:5], g_logic at [4:1], g_is_output at [0]}.
//   - On accept: k increments; xor counter increments if g_logic==4'b0110.
//   - Write latency is 1 cycle. Back-to-back accepts yield back-to-back writes with no bubble.
//   - Ordering check at accept: g_in0 and g_in1 must be < W = init_size+input_size+dff_size+k (unsigned, S+2-bit sum). Violation sets err; the word is still written.
//   - When k reaches gate_size: go to FIN.
//  FIN (1 cycle): done=1, busy=0. If xor counter != num_XOR, err is set in the same cycle done is high. Then return to IDLE.
//  busy=1 in HDR and GATES, including the final write cycle.
//  start outside IDLE is ignored. g_valid outside GATES is ignored and nothing is accepted.
//  Reset mid-image: immediate return to IDLE with outputs 0; the partial image stays in memory; no done pulse.
// TESTING
//  1. init=2,input=2,dff=0,out=1,gates=1,xor=1; gate in0=0,in1=2,logic=6,out=1
//     -> addr0..3 = 0x2,0x2,0x1,{1,1}; addr4 = {0,2,6,1} packed; done pulse; err=0.
//  2. gates=3, g_valid held high -> writes at addr 4,5,6 on consecutive cycles; g_ready drops after the 3rd accept.
//  3. g_valid toggled 1/0 -> writes are gapped identically; addresses are contiguous; k is correct.
//  4. Gate 0 with in1 = init+input+dff (index not yet defined) -> err=1 at accept; word still written; done still pulses.
//  5. num_XOR=2 with one XOR gate -> err=1 in the done cycle. gate_size=0 -> only 4 header writes, then done.
//  6. rst asserted during GATES after 2 of 5 gates -> all outputs 0 next edge. A following start rewrites the image from addr 0 with err cleared.

Source files
------------

// File: rtl/netlist_writer.sv
// ---------------------------------------------------------------------------
// netlist_writer
//   Builds the netlist image read by the garbling-side netlist reader from a
//   32-bit word memory. On start it latches the six header counts and writes
//   four header words at addresses 0..3. It then accepts gate records over a
//   valid/ready stream and writes one packed word per gate at address 4+k.
//   Operand ordering and the XOR count are checked. done pulses once when
//   the image is complete.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin a new image (only looked at in IDLE)
//   init_size .. num_XOR     header counts, latched on an accepted start
//   g_valid / g_ready        gate record handshake
//   g_in0, g_in1             operand wire indices
//   g_logic, g_is_output     truth table (4'b0110 = XOR), output flag
//   mem_we/mem_addr/mem_wdata  memory write port (registered)
//   busy                     high in HDR and GATES
//   done                     one-cycle pulse in FIN
//   err                      sticky error, cleared by the next accepted start
// ---------------------------------------------------------------------------
module netlist_writer #(
    parameter int S = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [S-1:0] init_size,
    input  logic [S-1:0] input_size,
    input  logic [S-1:0] dff_size,
    input  logic [S-1:0] output_size,
    input  logic [S-1:0] gate_size,
    input  logic [S-1:0] num_XOR,
    input  logic         g_valid,
    output logic         g_ready,
    input  logic [S-1:0] g_in0,
    input  logic [S-1:0] g_in1,
    input  logic [3:0]   g_logic,
    input  logic         g_is_output,
    output logic         mem_we,
    output logic [S-1:0] mem_addr,
    output logic [31:0]  mem_wdata,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, HDR, GATES, FIN} state_t;

    // Gate words start at address 4, so at most 2**S-5 gates fit the address space.
    localparam logic [S-1:0] MAX_GATES = S'((1 << S) - 5);

    state_t       state_reg, state_next;
    logic [1:0]   hdr_cnt_reg, hdr_cnt_next;
    logic [S-1:0] k_reg, k_next;
    logic [S-1:0] xor_cnt_reg, xor_cnt_next;
    logic [S-1:0] init_reg, init_next;
    logic [S-1:0] input_reg, input_next;
    logic [S-1:0] dff_reg, dff_next;
    logic [S-1:0] output_reg, output_next;
    logic [S-1:0] gate_reg, gate_next;
    logic [S-1:0] nxor_reg, nxor_next;
    logic         err_reg, err_next;
    logic         we_reg, we_next;
    logic [S-1:0] addr_reg, addr_next;
    logic [31:0]  wdata_reg, wdata_next;

    // Header words: {hi field at [2S-1:S], lo field at [S-1:0]}, rest zero.
    logic [S-1:0] hdr_hi [4];
    logic [S-1:0] hdr_lo [4];
    logic [31:0]  hdr_word [4];

    assign hdr_hi = '{'0, '0, dff_reg, nxor_reg};
    assign hdr_lo = '{init_reg, input_reg, output_reg, gate_reg};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hdr
            assign hdr_word[gi] = {{(32 - 2 * S){1'b0}}, hdr_hi[gi], hdr_lo[gi]};
        end
    endgenerate

    logic [1:0]   hdr_idx;
    logic [S+1:0] w_sum;
    logic         accept;
    logic         order_bad;
    logic [31:0]  gate_word;

    assign hdr_idx   = hdr_cnt_reg + 2'd1;
    // Number of wires defined before gate k; both operands must index below it.
    assign w_sum     = {2'b00, init_reg} + {2'b00, input_reg} + {2'b00, dff_reg} + {2'b00, k_reg};
    assign accept    = (state_reg == GATES) && g_valid && (k_reg < gate_reg);
    assign order_bad = ({2'b00, g_in0} >= w_sum) || ({2'b00, g_in1} >= w_sum);
    assign gate_word = {{(27 - 2 * S){1'b0}}, g_in0, g_in1, g_logic, g_is_output};

    // State and datapath register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            hdr_cnt_reg <= '0;
            k_reg       <= '0;
            xor_cnt_reg <= '0;
            init_reg    <= '0;
            input_reg   <= '0;
            dff_reg     <= '0;
            output_reg  <= '0;
            gate_reg    <= '0;
            nxor_reg    <= '0;
            err_reg     <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            hdr_cnt_reg <= hdr_cnt_next;
            k_reg       <= k_next;
            xor_cnt_reg <= xor_cnt_next;
            init_reg    <= init_next;
            input_reg   <= input_next;
            dff_reg     <= dff_next;
            output_reg  <= output_next;
            gate_reg    <= gate_next;
            nxor_reg    <= nxor_next;
            err_reg     <= err_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
        end
    end

    // Next-state logic. Writes are prepared one cycle ahead so the memory
    // port is fully registered.
    always_comb begin
        state_next   = state_reg;
        hdr_cnt_next = hdr_cnt_reg;
        k_next       = k_reg;
        xor_cnt_next = xor_cnt_reg;
        init_next    = init_reg;
        input_next   = input_reg;
        dff_next     = dff_reg;
        output_next  = output_reg;
        gate_next    = gate_reg;
        nxor_next    = nxor_reg;
        err_next     = err_reg;
        we_next      = 1'b0;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    if (gate_size > MAX_GATES) begin
                        err_next = 1'b1;
                    end else begin
                        init_next    = init_size;
                        input_next   = input_size;
                        dff_next     = dff_size;
                        output_next  = output_size;
                        gate_next    = gate_size;
                        nxor_next    = num_XOR;
                        err_next     = 1'b0;
                        k_next       = '0;
                        xor_cnt_next = '0;
                        hdr_cnt_next = 2'd0;
                        state_next   = HDR;
                        we_next      = 1'b1;
                        addr_next    = '0;
                        wdata_next   = {{(32 - S){1'b0}}, init_size};
                    end
                end
            end
            HDR: begin
                if (hdr_cnt_reg != 2'd3) begin
                    hdr_cnt_next = hdr_idx;
                    we_next      = 1'b1;
                    addr_next    = S'(hdr_idx);
                    wdata_next   = hdr_word[hdr_idx];
                end else if (gate_reg == '0) begin
                    state_next = FIN;
                    if (xor_cnt_reg != nxor_reg) err_next = 1'b1;
                end else begin
                    state_next = GATES;
                end
            end
            GATES: begin
                if (accept) begin
                    k_next     = k_reg + S'(1);
                    we_next    = 1'b1;
                    addr_next  = S'(4) + k_reg;
                    wdata_next = gate_word;
                    if (g_logic == 4'b0110) xor_cnt_next = xor_cnt_reg + S'(1);
                    if (order_bad) err_next = 1'b1;
                end
                // Leave only once the last write is on the port, so busy
                // covers it and FIN follows it directly.
                if (k_reg == gate_reg) begin
                    state_next = FIN;
                    if (xor_cnt_reg != nxor_reg) err_next = 1'b1;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        g_ready   = (state_reg == GATES) && (k_reg < gate_reg);
        busy      = (state_reg == HDR) || (state_reg == GATES);
        done      = (state_reg == FIN);
        err       = err_reg;
        mem_we    = we_reg;
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
    end

endmodule

// File: tb/tb_netlist_writer.sv
module tb_netlist_writer;
    localparam int S = 13;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [S-1:0] init_size = '0, input_size = '0, dff_size = '0;
    logic [S-1:0] output_size = '0, gate_size = '0, num_XOR = '0;
    logic         g_valid = 1'b0;
    logic         g_ready;
    logic [S-1:0] g_in0 = '0, g_in1 = '0;
    logic [3:0]   g_logic = '0;
    logic         g_is_output = 1'b0;
    logic         mem_we;
    logic [S-1:0] mem_addr;
    logic [31:0]  mem_wdata;
    logic         busy, done, err;

    netlist_writer #(.S(S)) dut (
        .clk(clk), .rst(rst), .start(start),
        .init_size(init_size), .input_size(input_size), .dff_size(dff_size),
        .output_size(output_size), .gate_size(gate_size), .num_XOR(num_XOR),
        .g_valid(g_valid), .g_ready(g_ready), .g_in0(g_in0), .g_in1(g_in1),
        .g_logic(g_logic), .g_is_output(g_is_output),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the expected sequence of memory writes for an image.
    typedef struct {
        int          addr;
        logic [31:0] data;
        logic        err;
    } wr_t;
    wr_t         exp_q[$];
    logic        exp_final_err = 1'b0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [31:0] shadow [16];
    int          wr_cyc [16];
    int          acc_cyc [8];
    int          ga [8], gb [8], gl [8], go [8];

    function automatic logic [31:0] pack_gate(input int a, input int b, input int l, input int o);
        return 32'((a << (S + 5)) | (b << 5) | (l << 1) | o);
    endfunction

    // Compare process: every write and every done pulse is checked against the model.
    always @(negedge clk) begin
        if (mem_we) begin
            $display("write addr=%0d data=0x%08h err=%0b cycle=%0d", mem_addr, mem_wdata, err, cyc);
            chk("busy_during_write", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(mem_addr), 32'(e.addr));
                chk("write_data", mem_wdata, e.data);
                chk("err_at_write", 32'(err), 32'(e.err));
            end
            if (mem_addr < 16) begin
                shadow[mem_addr] = mem_wdata;
                wr_cyc[mem_addr] = cyc;
            end
        end
        if (done) begin
            $display("done err=%0b cycle=%0d", err, cyc);
            done_cnt++;
            done_cyc = cyc;
            chk("busy_in_done", 32'(busy), 32'd0);
            chk("err_at_done", 32'(err), 32'(exp_final_err));
            chk("writes_pending_at_done", 32'(exp_q.size()), 32'd0);
        end
    end

    task automatic set_gate(input int i, input int a, input int b, input int l, input int o);
        ga[i] = a; gb[i] = b; gl[i] = l; go[i] = o;
    endtask

    // Runs one image. stop_after < 0: run to done; otherwise stop after that many accepts.
    task automatic run_image(input int ini, input int inp, input int dff, input int outs,
                             input int gates, input int nx, input bit toggle, input int stop_after);
        int err_acc = 0;
        int xcnt = 0;
        int n_gate;
        int idx = 0;
        int budget = 0;
        int start_cyc;
        int done_before;
        wr_t w;
        n_gate = (stop_after < 0) ? gates : stop_after;
        w.err = 1'b0;
        w.addr = 0; w.data = 32'(ini);              exp_q.push_back(w);
        w.addr = 1; w.data = 32'(inp);              exp_q.push_back(w);
        w.addr = 2; w.data = 32'((dff << S) | outs); exp_q.push_back(w);
        w.addr = 3; w.data = 32'((nx << S) | gates); exp_q.push_back(w);
        for (int k = 0; k < gates; k++) begin
            if (ga[k] >= ini + inp + dff + k || gb[k] >= ini + inp + dff + k) err_acc = 1;
            if (gl[k] == 6) xcnt++;
            if (k < n_gate) begin
                w.addr = 4 + k; w.data = pack_gate(ga[k], gb[k], gl[k], go[k]); w.err = (err_acc != 0);
                exp_q.push_back(w);
            end
        end
        exp_final_err = (err_acc != 0) || (xcnt != nx);
        done_before = done_cnt;

        @(posedge clk); #1;
        init_size = S'(ini); input_size = S'(inp); dff_size = S'(dff);
        output_size = S'(outs); gate_size = S'(gates); num_XOR = S'(nx);
        start = 1'b1;
        @(negedge clk); start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;

        while (idx < n_gate && budget < 100) begin
            g_in0 = S'(ga[idx]); g_in1 = S'(gb[idx]);
            g_logic = 4'(gl[idx]); g_is_output = go[idx][0];
            g_valid = toggle ? (budget % 2 == 0) : 1'b1;
            @(negedge clk);
            if (g_valid && g_ready) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            @(posedge clk); #1;
            budget++;
        end
        chk("gates_accepted", 32'(idx), 32'(n_gate));
        g_valid = 1'b0;
        @(negedge clk);
        chk("g_ready_after_accepts", 32'(g_ready), (n_gate < gates) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        if (stop_after >= 0) return;

        for (int i = 0; i < 40 && done_cnt == done_before; i++) @(posedge clk);
        chk("done_pulses", 32'(done_cnt), 32'(done_before + 1));
        for (int h = 0; h < 4; h++) chk("hdr_write_cycle", 32'(wr_cyc[h]), 32'(start_cyc + 1 + h));
        for (int k = 0; k < gates; k++) chk("gate_write_latency", 32'(wr_cyc[4 + k]), 32'(acc_cyc[k] + 1));
        chk("done_after_last_write", 32'(done_cyc), 32'(wr_cyc[3 + gates] + 1));
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        for (int i = 0; i < 16; i++) begin shadow[i] = '0; wr_cyc[i] = 0; end
        // Reset state
        @(negedge clk);
        chk("reset_mem_we", 32'(mem_we), 0); chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);     chk("reset_err", 32'(err), 0);
        chk("reset_g_ready", 32'(g_ready), 0); chk("reset_addr", 32'(mem_addr), 0);
        chk("reset_wdata", mem_wdata, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Oversized gate count: err set, no image started
        @(posedge clk); #1;
        gate_size = S'((1 << S) - 4); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("oversize_err", 32'(err), 1); chk("oversize_busy", 32'(busy), 0);
        end

        // 1. Single XOR gate image
        set_gate(0, 0, 2, 6, 1);
        run_image(2, 2, 0, 1, 1, 1, 1'b0, -1);
        chk("t1_word0", shadow[0], 32'h2);
        chk("t1_word2", shadow[2], 32'h1);
        chk("t1_word3", shadow[3], 32'h2001);
        chk("t1_word4", shadow[4], 32'h4D);
        chk("t1_err", 32'(err), 0);

        // 2. Back-to-back gates
        set_gate(0, 0, 1, 6, 0); set_gate(1, 2, 6, 8, 0); set_gate(2, 6, 5, 6, 1);
        run_image(3, 2, 1, 2, 3, 2, 1'b0, -1);
        chk("t2_b2b_1", 32'(wr_cyc[5] - wr_cyc[4]), 1);
        chk("t2_b2b_2", 32'(wr_cyc[6] - wr_cyc[5]), 1);

        // 3. Gapped valid
        set_gate(0, 0, 3, 1, 0); set_gate(1, 4, 1, 6, 0); set_gate(2, 2, 5, 7, 1);
        run_image(3, 1, 0, 1, 3, 1, 1'b1, -1);
        chk("t3_gap", 32'(wr_cyc[5] - wr_cyc[4]), 2);

        // 4. Operand not yet defined
        set_gate(0, 0, 4, 8, 0); set_gate(1, 3, 4, 14, 1);
        run_image(2, 1, 1, 1, 2, 0, 1'b0, -1);
        chk("t4_err_sticky", 32'(err), 1);

        // 5a. XOR count mismatch; 5b. empty gate list
        set_gate(0, 0, 1, 6, 1);
        run_image(1, 1, 0, 1, 1, 2, 1'b0, -1);
        chk("t5_xor_err", 32'(err), 1);
        run_image(4, 2, 1, 3, 0, 0, 1'b0, -1);
        chk("t5_empty_err", 32'(err), 0);

        // 6. Reset in the middle of the gate stream, then a fresh image
        set_gate(0, 0, 1, 8, 0); set_gate(1, 2, 3, 14, 0); set_gate(2, 4, 5, 8, 0);
        set_gate(3, 1, 6, 2, 0); set_gate(4, 7, 3, 8, 1);
        dc = done_cnt;
        run_image(2, 2, 0, 1, 5, 0, 1'b0, 2);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 0); chk("t6_rst_g_ready", 32'(g_ready), 0);
        chk("t6_rst_we", 32'(mem_we), 0); chk("t6_rst_done", 32'(done), 0);
        chk("t6_partial_writes", 32'(exp_q.size()), 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("t6_no_done", 32'(done_cnt), 32'(dc));
        run_image(2, 2, 0, 1, 5, 0, 1'b0, -1);
        chk("t6_word4", shadow[4], 32'h0000_0030);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
